cpu_mmio_path_regs: RTL and testbench

- Memory-mapped register bank at base 0x02000000, serving the CPU's load/store bus and the external (driver) write port.
- Holds START_POINT, END_POINT, NODE_POINT and CPU_DONE, which the driver programs while the CPU is held in reset.
- Logs every node the CPU writes into a 16-deep path log and flags completion.
- Sits between the driver's Ext write port and the CPU data bus, alongside data memory.

---
 rtl/cpu_mmio_path_regs.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_mmio_path_regs.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mmio_path_regs.sv
// cpu_mmio_path_regs
// Memory-mapped register bank shared by the driver's external write port and
// the CPU load/store bus. Holds the path endpoints (SP/EP), the current node,
// the completion flag, and a small log of every node the CPU has visited.
// Bus ownership is selected by CPU_reset: while the CPU is held the driver
// programs the bank; once released only the CPU can write.

module cpu_mmio_path_regs #(
    parameter logic [31:0] BASE_ADR  = 32'h02000000,
    parameter int          LOG_DEPTH = 16,
    parameter int          NODE_W    = 5
) (
    input  logic              clk_3125KHz,
    input  logic              rst_n,
    input  logic              CPU_reset,
    input  logic              Ext_MemWrite,
    input  logic [31:0]       Ext_DataAdr,
    input  logic [31:0]       Ext_WriteData,
    input  logic              CPU_MemWrite,
    input  logic [31:0]       CPU_DataAdr,
    input  logic [31:0]       CPU_WriteData,
    output logic [31:0]       CPU_ReadData,
    output logic              mmio_hit,
    output logic              node_strobe,
    output logic [NODE_W-1:0] node_data,
    output logic              done_pulse,
    output logic [4:0]        log_count,
    output logic              log_overflow
);

    // Register selector produced by the address decoder.
    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_SP     = 3'd1,
        SEL_EP     = 3'd2,
        SEL_NODE   = 3'd3,
        SEL_DONE   = 3'd4,
        SEL_STATUS = 3'd5,
        SEL_LOG    = 3'd6
    } reg_sel_e;

    localparam logic [4:0] LOG_FULL_COUNT = 5'(LOG_DEPTH);

    // Map an absolute bus address onto a register. The window spans 0x80 bytes
    // above BASE_ADR; anything misaligned, beyond the window, or in a hole of
    // the map selects nothing.
    function automatic reg_sel_e decode_sel(input logic [31:0] adr);
        logic [31:0] off;
        reg_sel_e    sel;
        off = adr - BASE_ADR;
        sel = SEL_NONE;
        if (off[31:7] == 25'd0 && off[1:0] == 2'b00) begin
            if (off[6]) begin
                if ({28'd0, off[5:2]} < 32'(LOG_DEPTH)) begin
                    sel = SEL_LOG;
                end
            end else begin
                case (off[5:2])
                    4'd0:    sel = SEL_SP;
                    4'd1:    sel = SEL_EP;
                    4'd2:    sel = SEL_NODE;
                    4'd3:    sel = SEL_DONE;
                    4'd4:    sel = SEL_STATUS;
                    default: sel = SEL_NONE;
                endcase
            end
        end
        return sel;
    endfunction

    // Word index inside the log region (only meaningful when decode_sel
    // returned SEL_LOG).
    function automatic logic [3:0] decode_log_idx(input logic [31:0] adr);
        logic [31:0] off;
        off = adr - BASE_ADR;
        return off[5:2];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NODE_W-1:0] sp_reg;
    logic [NODE_W-1:0] ep_reg;
    logic [NODE_W-1:0] node_reg;
    logic              done_reg;
    logic [4:0]        log_count_reg;
    logic              log_overflow_reg;
    logic              node_strobe_reg;
    logic [NODE_W-1:0] node_data_reg;
    logic              done_pulse_reg;
    logic [NODE_W-1:0] log_reg [LOG_DEPTH];

    // ------------------------------------------------------------------
    // Write-port arbitration: exactly one port may commit per cycle,
    // chosen by CPU_reset, so the two sides can never collide.
    // ------------------------------------------------------------------
    logic              ext_we;
    logic              cpu_we;
    logic [31:0]       wr_adr;
    logic [31:0]       wr_data;
    logic [NODE_W-1:0] wr_node;
    reg_sel_e          wr_sel;

    assign ext_we  = CPU_reset & Ext_MemWrite;
    assign cpu_we  = ~CPU_reset & CPU_MemWrite;
    assign wr_adr  = CPU_reset ? Ext_DataAdr   : CPU_DataAdr;
    assign wr_data = CPU_reset ? Ext_WriteData : CPU_WriteData;
    assign wr_node = wr_data[NODE_W-1:0];
    assign wr_sel  = decode_sel(wr_adr);

    // Upper data bits are not stored by any register in this bank.
    logic unused_wr_data_hi;
    assign unused_wr_data_hi = ^wr_data[31:NODE_W];

    logic any_we;
    logic cpu_node_wr;
    logic cpu_done_wr;
    logic ext_done_wr;
    logic log_full;
    logic log_wr_en;

    assign any_we      = ext_we | cpu_we;
    assign cpu_node_wr = cpu_we & (wr_sel == SEL_NODE);
    assign cpu_done_wr = cpu_we & (wr_sel == SEL_DONE);
    assign ext_done_wr = ext_we & (wr_sel == SEL_DONE);
    assign log_full    = (log_count_reg == LOG_FULL_COUNT);
    assign log_wr_en   = cpu_node_wr & ~log_full;

    // Configuration registers, completion flag, log bookkeeping and the
    // one-cycle event pulses.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg           <= '0;
            ep_reg           <= '0;
            node_reg         <= '0;
            done_reg         <= 1'b0;
            log_count_reg    <= '0;
            log_overflow_reg <= 1'b0;
            node_strobe_reg  <= 1'b0;
            node_data_reg    <= '0;
            done_pulse_reg   <= 1'b0;
        end else begin
            // Pulses are single-cycle by construction: recomputed every edge.
            node_strobe_reg <= cpu_node_wr;
            done_pulse_reg  <= cpu_done_wr & wr_data[0] & ~done_reg;

            if (any_we && wr_sel == SEL_SP) begin
                sp_reg <= wr_node;
            end
            if (any_we && wr_sel == SEL_EP) begin
                ep_reg <= wr_node;
            end
            if (any_we && wr_sel == SEL_NODE) begin
                node_reg <= wr_node;
            end

            // Only CPU node writes are path steps; driver writes to NODE
            // are plain configuration and leave the log alone.
            if (cpu_node_wr) begin
                node_data_reg <= wr_node;
                if (log_full) begin
                    log_overflow_reg <= 1'b1;
                end else begin
                    log_count_reg <= log_count_reg + 5'd1;
                end
            end

            if (cpu_done_wr) begin
                done_reg <= wr_data[0];
            end

            // A driver write to DONE restarts the session regardless of data.
            if (ext_done_wr) begin
                done_reg         <= 1'b0;
                log_count_reg    <= '0;
                log_overflow_reg <= 1'b0;
            end
        end
    end

    // Path log: each entry captures the node when the write pointer reaches it.
    generate
        for (genvar gi = 0; gi < LOG_DEPTH; gi++) begin : g_log
            always_ff @(posedge clk_3125KHz or negedge rst_n) begin
                if (!rst_n) begin
                    log_reg[gi] <= '0;
                end else if (log_wr_en && log_count_reg == 5'(gi)) begin
                    log_reg[gi] <= wr_node;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // CPU read path (combinational, follows CPU_DataAdr directly)
    // ------------------------------------------------------------------
    reg_sel_e   rd_sel;
    logic [3:0] rd_log_idx;

    assign rd_sel     = decode_sel(CPU_DataAdr);
    assign rd_log_idx = decode_log_idx(CPU_DataAdr);

    // Read mux: zero-extend stored fields, zero for anything unmapped.
    always_comb begin
        CPU_ReadData = 32'd0;
        mmio_hit     = (rd_sel != SEL_NONE);
        case (rd_sel)
            SEL_SP:     CPU_ReadData = {{(32-NODE_W){1'b0}}, sp_reg};
            SEL_EP:     CPU_ReadData = {{(32-NODE_W){1'b0}}, ep_reg};
            SEL_NODE:   CPU_ReadData = {{(32-NODE_W){1'b0}}, node_reg};
            SEL_DONE:   CPU_ReadData = {31'd0, done_reg};
            SEL_STATUS: CPU_ReadData = {22'd0, done_reg, log_overflow_reg,
                                        3'd0, log_count_reg};
            SEL_LOG:    CPU_ReadData = {{(32-NODE_W){1'b0}}, log_reg[rd_log_idx]};
            default:    CPU_ReadData = 32'd0;
        endcase
    end

    assign node_strobe  = node_strobe_reg;
    assign node_data    = node_data_reg;
    assign done_pulse   = done_pulse_reg;
    assign log_count    = log_count_reg;
    assign log_overflow = log_overflow_reg;

endmodule

// File: tb/tb_cpu_mmio_path_regs.sv
// Bench for cpu_mmio_path_regs: driver programming, node logging, DONE
// handling, log overflow/restart, address decode and asynchronous reset.
// Expected read data and expected node strobes are queued when stimulus is
// driven and compared when the DUT presents them.

module tb_cpu_mmio_path_regs;

    localparam logic [31:0] BASE   = 32'h02000000;
    localparam logic [31:0] A_SP   = BASE + 32'h00;
    localparam logic [31:0] A_EP   = BASE + 32'h04;
    localparam logic [31:0] A_NODE = BASE + 32'h08;
    localparam logic [31:0] A_DONE = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
    localparam logic [31:0] A_LOG  = BASE + 32'h40;

    logic        clk;
    logic        rst_n;
    logic        CPU_reset;
    logic        Ext_MemWrite;
    logic [31:0] Ext_DataAdr;
    logic [31:0] Ext_WriteData;
    logic        CPU_MemWrite;
    logic [31:0] CPU_DataAdr;
    logic [31:0] CPU_WriteData;
    logic [31:0] CPU_ReadData;
    logic        mmio_hit;
    logic        node_strobe;
    logic [4:0]  node_data;
    logic        done_pulse;
    logic [4:0]  log_count;
    logic        log_overflow;

    cpu_mmio_path_regs dut (
        .clk_3125KHz  (clk),
        .rst_n        (rst_n),
        .CPU_reset    (CPU_reset),
        .Ext_MemWrite (Ext_MemWrite),
        .Ext_DataAdr  (Ext_DataAdr),
        .Ext_WriteData(Ext_WriteData),
        .CPU_MemWrite (CPU_MemWrite),
        .CPU_DataAdr  (CPU_DataAdr),
        .CPU_WriteData(CPU_WriteData),
        .CPU_ReadData (CPU_ReadData),
        .mmio_hit     (mmio_hit),
        .node_strobe  (node_strobe),
        .node_data    (node_data),
        .done_pulse   (done_pulse),
        .log_count    (log_count),
        .log_overflow (log_overflow)
    );

    // 3.125 MHz -> 320 ns period
    initial clk = 1'b0;
    always #160 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [4:0] node_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic ext, input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        if (ext) begin
            Ext_MemWrite  = 1'b1;
            Ext_DataAdr   = adr;
            Ext_WriteData = data;
        end else begin
            CPU_MemWrite  = 1'b1;
            CPU_DataAdr   = adr;
            CPU_WriteData = data;
        end
        $display("WR %s adr=0x%08h data=0x%08h CPU_reset=%0b", ext ? "EXT" : "CPU", adr, data, CPU_reset);
        @(negedge clk);
        Ext_MemWrite = 1'b0;
        CPU_MemWrite = 1'b0;
    endtask

    // CPU node store that is expected to produce a node_strobe.
    task automatic cpu_node(input logic [4:0] v);
        node_q.push_back(v);
        bus_wr(1'b0, A_NODE, {27'd0, v});
    endtask

    // Combinational read, no clock edge involved.
    task automatic peek(input string tag, input logic [31:0] adr,
                        input logic [31:0] exp, input logic exp_hit);
        rd_exp_t e;
        CPU_DataAdr = adr;
        rd_q.push_back('{tag, exp});
        #1;
        e = rd_q.pop_front();
        $display("RD adr=0x%08h data=0x%08h hit=%0b", adr, CPU_ReadData, mmio_hit);
        chk(e.tag, CPU_ReadData, e.exp);
        chk({tag, "_hit"}, {31'd0, mmio_hit}, {31'd0, exp_hit});
    endtask

    task automatic rd(input string tag, input logic [31:0] adr,
                      input logic [31:0] exp, input logic exp_hit);
        @(negedge clk);
        peek(tag, adr, exp, exp_hit);
    endtask

    task automatic set_cpu_reset(input logic v);
        @(negedge clk);
        CPU_reset = v;
    endtask

    // Monitor: every strobe must match the oldest queued node.
    always @(negedge clk) begin
        if (node_strobe) begin
            strobe_cnt++;
            chk("strobe_pending", {31'd0, node_q.size() != 0}, 32'd1);
            if (node_q.size() != 0) begin
                logic [4:0] e;
                e = node_q.pop_front();
                chk("node_data", {27'd0, node_data}, {27'd0, e});
            end
        end
        if (done_pulse) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        CPU_reset = 1'b1;
        Ext_MemWrite = 1'b0;
        Ext_DataAdr = '0;
        Ext_WriteData = '0;
        CPU_MemWrite = 1'b0;
        CPU_DataAdr = A_STAT;
        CPU_WriteData = '0;
        #5;
        chk("rst_status", CPU_ReadData, 32'd0);
        chk("rst_strobe", {31'd0, node_strobe}, 32'd0);
        chk("rst_count", {27'd0, log_count}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: driver programming while CPU held
        bus_wr(1'b1, A_SP, 32'd3);
        bus_wr(1'b1, A_EP, 32'd17);
        bus_wr(1'b1, A_NODE, 32'd0);
        bus_wr(1'b1, A_DONE, 32'd0);
        bus_wr(1'b0, A_SP, 32'd9);      // CPU write while held: ignored
        bus_wr(1'b0, A_NODE, 32'd9);    // ignored, no strobe
        set_cpu_reset(1'b0);
        bus_wr(1'b1, A_EP, 32'd5);      // Ext write while CPU runs: ignored
        rd("t1_sp", A_SP, 32'd3, 1'b1);
        rd("t1_ep", A_EP, 32'd17, 1'b1);
        rd("t1_node", A_NODE, 32'd0, 1'b1);
        rd("t1_status", A_STAT, 32'd0, 1'b1);

        // 2: node logging
        cpu_node(5'd3);
        cpu_node(5'd7);
        cpu_node(5'd12);
        cpu_node(5'd17);
        chk("t2_count", {27'd0, log_count}, 32'd4);
        rd("t2_log0", A_LOG + 0, 32'd3, 1'b1);
        rd("t2_log1", A_LOG + 4, 32'd7, 1'b1);
        rd("t2_log2", A_LOG + 8, 32'd12, 1'b1);
        rd("t2_log3", A_LOG + 12, 32'd17, 1'b1);
        rd("t2_node", A_NODE, 32'd17, 1'b1);

        // 3: DONE written twice -> one pulse
        bus_wr(1'b0, A_DONE, 32'd1);
        bus_wr(1'b0, A_DONE, 32'd1);
        @(negedge clk);
        chk("t3_done_pulses", done_cnt, 1);
        rd("t3_status", A_STAT, 32'h204, 1'b1);
        rd("t3_done", A_DONE, 32'd1, 1'b1);

        // 4: restart, then overflow the log
        set_cpu_reset(1'b1);
        bus_wr(1'b1, A_DONE, 32'd0);
        set_cpu_reset(1'b0);
        rd("t4_restart_status", A_STAT, 32'd0, 1'b1);
        for (int i = 0; i < 18; i++) cpu_node(5'(10 + i));
        @(negedge clk);
        chk("t4_count", {27'd0, log_count}, 32'd16);
        chk("t4_overflow", {31'd0, log_overflow}, 32'd1);
        chk("t4_strobes", strobe_cnt, 22);
        rd("t4_log0", A_LOG, 32'd10, 1'b1);
        rd("t4_log15", A_LOG + 60, 32'd25, 1'b1);
        rd("t4_node", A_NODE, 32'd27, 1'b1);
        rd("t4_status", A_STAT, 32'h110, 1'b1);
        set_cpu_reset(1'b1);
        bus_wr(1'b1, A_DONE, 32'd1);
        set_cpu_reset(1'b0);
        chk("t4_clr_count", {27'd0, log_count}, 32'd0);
        chk("t4_clr_overflow", {31'd0, log_overflow}, 32'd0);
        rd("t4_clr_status", A_STAT, 32'd0, 1'b1);

        // 5: decode holes and read-only registers
        rd("t5_misaligned", BASE + 32'h02, 32'd0, 1'b0);
        rd("t5_hole", BASE + 32'h20, 32'd0, 1'b0);
        rd("t5_outside", 32'h03000000, 32'd0, 1'b0);
        bus_wr(1'b0, A_STAT, 32'hFFFF_FFFF);
        bus_wr(1'b0, A_LOG, 32'd3);
        rd("t5_status_ro", A_STAT, 32'd0, 1'b1);
        rd("t5_log0_ro", A_LOG, 32'd10, 1'b1);

        // 6: asynchronous reset mid-session
        bus_wr(1'b0, A_DONE, 32'd1);
        for (int i = 1; i <= 4; i++) cpu_node(5'(i));
        @(negedge clk);
        CPU_MemWrite  = 1'b1;
        CPU_DataAdr   = A_NODE;
        CPU_WriteData = 32'd5;
        $display("WR CPU adr=0x%08h data=0x%08h CPU_reset=%0b", A_NODE, 32'd5, CPU_reset);
        @(posedge clk);
        #2;
        chk("t6_pre_strobe", {31'd0, node_strobe}, 32'd1);
        chk("t6_pre_data", {27'd0, node_data}, 32'd5);
        chk("t6_pre_count", {27'd0, log_count}, 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_strobe", {31'd0, node_strobe}, 32'd0);
        chk("t6_data", {27'd0, node_data}, 32'd0);
        chk("t6_count", {27'd0, log_count}, 32'd0);
        chk("t6_overflow", {31'd0, log_overflow}, 32'd0);
        chk("t6_done_pulse", {31'd0, done_pulse}, 32'd0);
        peek("t6_sp", A_SP, 32'd0, 1'b1);
        peek("t6_ep", A_EP, 32'd0, 1'b1);
        peek("t6_log0", A_LOG, 32'd0, 1'b1);
        peek("t6_status", A_STAT, 32'd0, 1'b1);
        @(negedge clk);
        CPU_MemWrite = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_queue_drained", node_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
